dac_i2s_serializer: RTL and testbench
=====================================

// Module: dac_i2s_serializer
// PURPOSE
//  Host-side I2S transmitter for a 2-channel DAC slot: accepts stereo sample pairs over a
//  valid/ready handshake and drives bck/lrck/sdata onto slotdata[5]/[3]/[4] of the 30-pin slot.
//  Sits directly upstream of the slot's I2S receiver; standard I2S framing (MSB one bck after
//  lrck edge, lrck low = left), data launched on bck falling edge, sampled by receiver on rising.
// PARAMETERS
//  SAMPLE_WIDTH  24  bits per channel sample; must satisfy 1 <= SAMPLE_WIDTH <= SLOT_BITS
//  SLOT_BITS     32  bck periods per channel slot (frame = 2*SLOT_BITS bck periods)
//  BCK_DIV       4   clk cycles per bck half-period (>=1); bck = clk/(2*BCK_DIV)
// PORTS
//  clk       in   1             system clock
//  reset     in   1             synchronous, active-high reset
//  enable    in   1             0 = synchronous clear to reset state (same effect as reset)
//  in_valid  in   1             sample pair available
//  in_ready  out  1             pair accepted this cycle when in_valid & in_ready
//  in_left   in   SAMPLE_WIDTH  left sample (two's complement, passed through unmodified)
//  in_right  in   SAMPLE_WIDTH  right sample
//  bck       out  1             bit clock -> slotdata[5]
//  lrck      out  1             word select -> slotdata[3]
//  sdata     out  1             serial data -> slotdata[4]
//  underflow out  1             1-cycle pulse: no pair available at load point
//  frame_start out 1            1-cycle pulse when left slot bit 0 (b=0) begins
// BEHAVIOUR
//  - Reset/enable=0: bck=0, lrck=0, sdata=0, in_ready=0, underflow=0, frame_start=0,
//    div counter=0, bit counter b=2*SLOT_BITS-2, holding regs L/R=0. Outputs registered.
//  - Divider: div increments each clk; at div==BCK_DIV-1 it wraps to 0 and bck toggles.
//    First toggle (rise) in BCK_DIV-th cycle after reset release, first fall in 2*BCK_DIV-th.
//  - Bit counter b in 0..2*SLOT_BITS-1 advances (mod 2*SLOT_BITS) on each bck falling toggle;
//    lrck and sdata update on the same clk edge as bck falls, never on rising toggles.
//  - lrck = 1 for b in [SLOT_BITS-1, 2*SLOT_BITS-2], else 0 (one-bck I2S lead).
//  - sdata = L[SAMPLE_WIDTH-1-b] for b < SAMPLE_WIDTH; R[SAMPLE_WIDTH-1-(b-SLOT_BITS)] for
//    SLOT_BITS <= b < SLOT_BITS+SAMPLE_WIDTH; 0 otherwise (zero pad).
//  - Load point: cycle whose falling toggle takes b from 2*SLOT_BITS-2 to 2*SLOT_BITS-1.
//    in_ready is high combinationally in exactly that cycle (and only when enable & !reset).
//    If in_valid: L/R <= in_left/in_right on that edge. Else: L/R <= 0 and underflow pulses
//    the following cycle. Pair is never partially consumed; in_ready never high elsewhere.
//  - frame_start pulses the cycle after b becomes 0.
//  - Frame period = 4*SLOT_BITS*BCK_DIV clk cycles (512 at defaults); first load point is the
//    first falling toggle after reset, so first in_ready at cycle 2*BCK_DIV.
//  - Reset or enable drop mid-frame: state cleared next edge, current pair discarded, no
//    underflow pulse; bck may be cut short (receiver resyncs on lrck).
//  - Simultaneous reset and load point: reset wins, in_ready=0, no transfer.
// TESTING
//  1. Hold reset 3 cycles with in_valid=1 -> all outputs 0, in_ready never 1; release ->
//     in_ready high exactly in cycle 8 (defaults).
//  2. One pair L=24'hA5A5A5, R=24'h5A5A5A -> i2s_receiver model captures same pair; MSB at
//     2nd bck after lrck edge; 8 pad bits per slot read 0; lrck low during left slot.
//  3. Four back-to-back pairs 1,2,3,4 (valid always high) -> bck period 8 clk, frame 512 clk,
//     frame_start spacing 512, receiver sees 1..4 in order, underflow never pulses.
//  4. in_valid=0 at one load point between pairs 7 and 8 -> one underflow pulse, one all-zero
//     frame, then pair 8 transmitted correctly.
//  5. Drop enable at b=10 for 5 cycles -> outputs at reset values next cycle; on re-enable
//     first in_ready after 2*BCK_DIV cycles, next pair transmitted intact.
//  6. Rerun 2-4 with BCK_DIV=1, SAMPLE_WIDTH=16 -> bck toggles every clk, 16 pad bits, data ok.

Source files
------------

// File: rtl/dac_i2s_serializer.sv
// dac_i2s_serializer
//   Host-side I2S transmitter for a 2-channel DAC slot. Stereo pairs arrive over
//   a valid/ready handshake and are shifted out MSB first with standard I2S
//   framing: lrck low = left, lrck leads the MSB by one bck, data launched on
//   the bck falling edge so the receiver samples on the rising edge.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   enable       0 = synchronous clear to the reset state
//   in_valid     sample pair available
//   in_ready     high (combinationally) only in the load cycle of each frame
//   in_left      left sample, two's complement, passed through unmodified
//   in_right     right sample
//   bck          bit clock   (slotdata[5])
//   lrck         word select (slotdata[3])
//   sdata        serial data (slotdata[4])
//   underflow    1-cycle pulse: no pair was offered at the load point
//   frame_start  1-cycle pulse when left-slot bit 0 begins
module dac_i2s_serializer #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_BITS    = 32,
  parameter int BCK_DIV      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SAMPLE_WIDTH-1:0] in_left,
  input  logic [SAMPLE_WIDTH-1:0] in_right,
  output logic                    bck,
  output logic                    lrck,
  output logic                    sdata,
  output logic                    underflow,
  output logic                    frame_start
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int B_W        = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;
  localparam int IDX_W      = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
  localparam logic [B_W-1:0]   B_LAST   = B_W'(FRAME_BITS - 1);
  localparam logic [B_W-1:0]   B_LOAD   = B_W'(FRAME_BITS - 2);

  // Serial bit for frame position b: left word in [0, SW), right word in
  // [SLOT_BITS, SLOT_BITS+SW), zero pad everywhere else.
  function automatic logic slot_bit(input logic [B_W-1:0]          b,
                                    input logic [SAMPLE_WIDTH-1:0] l,
                                    input logic [SAMPLE_WIDTH-1:0] r);
    int               bi;
    logic [IDX_W-1:0] idx;
    logic             bit_o;
    bi    = int'(b);
    idx   = '0;
    bit_o = 1'b0;
    if (bi < SAMPLE_WIDTH) begin
      idx   = IDX_W'(SAMPLE_WIDTH - 1 - bi);
      bit_o = l[idx];
    end else if (bi >= SLOT_BITS && bi < SLOT_BITS + SAMPLE_WIDTH) begin
      idx   = IDX_W'(SAMPLE_WIDTH - 1 - (bi - SLOT_BITS));
      bit_o = r[idx];
    end
    return bit_o;
  endfunction

  // lrck switches one bck ahead of each word, so the right-channel level spans
  // positions SLOT_BITS-1 .. FRAME_BITS-2.
  function automatic logic lrck_level(input logic [B_W-1:0] b);
    return (int'(b) >= SLOT_BITS - 1) && (b <= B_LOAD);
  endfunction

  logic [DIV_W-1:0]        div_q, div_d;
  logic                    bck_q, bck_d;
  logic [B_W-1:0]          b_q, b_d, b_nxt;
  logic                    lrck_q, lrck_d;
  logic                    sdata_q, sdata_d;
  logic [SAMPLE_WIDTH-1:0] left_q, left_d;
  logic [SAMPLE_WIDTH-1:0] right_q, right_d;
  logic                    underflow_q, underflow_d;
  logic                    frame_start_q, frame_start_d;

  logic clr;
  logic bck_tick;
  logic fall_tick;
  logic load;

  assign clr       = reset | ~enable;
  assign bck_tick  = (div_q == DIV_LAST);
  assign fall_tick = bck_tick & bck_q;
  // Load point: the falling toggle that moves b into the last (pad) position
  // of the right slot, one bck before the next left MSB.
  assign load      = fall_tick & (b_q == B_LOAD);
  assign in_ready  = load & ~clr;

  always_comb begin
    div_d         = bck_tick ? '0 : div_q + DIV_W'(1);
    bck_d         = bck_tick ? ~bck_q : bck_q;
    b_nxt         = (b_q == B_LAST) ? '0 : b_q + B_W'(1);
    b_d           = b_q;
    lrck_d        = lrck_q;
    sdata_d       = sdata_q;
    left_d        = left_q;
    right_d       = right_q;
    underflow_d   = 1'b0;
    frame_start_d = 1'b0;

    // lrck/sdata only ever move on the falling toggle.
    if (fall_tick) begin
      b_d           = b_nxt;
      lrck_d        = lrck_level(b_nxt);
      sdata_d       = slot_bit(b_nxt, left_q, right_q);
      frame_start_d = (b_nxt == '0);
    end

    // A missing pair is replaced by silence rather than repeating old data.
    if (load) begin
      left_d      = in_valid ? in_left  : '0;
      right_d     = in_valid ? in_right : '0;
      underflow_d = ~in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      div_q         <= '0;
      bck_q         <= 1'b0;
      b_q           <= B_LOAD;
      lrck_q        <= 1'b0;
      sdata_q       <= 1'b0;
      left_q        <= '0;
      right_q       <= '0;
      underflow_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      bck_q         <= bck_d;
      b_q           <= b_d;
      lrck_q        <= lrck_d;
      sdata_q       <= sdata_d;
      left_q        <= left_d;
      right_q       <= right_d;
      underflow_q   <= underflow_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bck         = bck_q;
  assign lrck        = lrck_q;
  assign sdata       = sdata_q;
  assign underflow   = underflow_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_dac_i2s_serializer.sv
// Bench for dac_i2s_serializer: instance 0 uses the default geometry
// (24-bit samples, BCK_DIV=4), instance 1 uses 16-bit samples with BCK_DIV=1.
// Only one instance is out of reset at a time. Expected bck/lrck/in_ready/
// underflow/frame_start come from cycle arithmetic on the count of enabled
// cycles; serial data is recovered by an I2S receiver model and compared with
// the pairs the bench offered.
module tb_dac_i2s_serializer;
  localparam int SLOT = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1, enable, in_valid;
  logic [23:0] in_left, in_right;
  logic        rdy0, bck0, lrck0, sd0, uf0, fs0;
  logic        rdy1, bck1, lrck1, sd1, uf1, fs1;

  dac_i2s_serializer #(.SAMPLE_WIDTH(24), .SLOT_BITS(SLOT), .BCK_DIV(4)) dut0 (
    .clk(clk), .reset(rst0), .enable(enable), .in_valid(in_valid), .in_ready(rdy0),
    .in_left(in_left), .in_right(in_right), .bck(bck0), .lrck(lrck0), .sdata(sd0),
    .underflow(uf0), .frame_start(fs0));

  dac_i2s_serializer #(.SAMPLE_WIDTH(16), .SLOT_BITS(SLOT), .BCK_DIV(1)) dut1 (
    .clk(clk), .reset(rst1), .enable(enable), .in_valid(in_valid), .in_ready(rdy1),
    .in_left(in_left[15:0]), .in_right(in_right[15:0]), .bck(bck1), .lrck(lrck1), .sdata(sd1),
    .underflow(uf1), .frame_start(fs1));

  int          total = 0;
  int          bad = 0;
  logic        sel;
  int          bd, sw, frame_p;
  logic [23:0] smask;
  int          run_cnt;
  logic        accepted, uf_exp, obs_uf;
  logic [47:0] exp_q[$];
  logic [31:0] rx_word;
  int          rx_cnt, rx_pairs;
  logic        rx_lr_prev, rx_bck_prev, rx_have_left;
  logic [23:0] rx_left;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rx_clear();
    rx_cnt       = 0;
    rx_have_left = 1'b0;
    rx_lr_prev   = 1'b0;
    rx_bck_prev  = 1'b0;
  endtask

  task automatic tick();
    logic        clr, load, o_rdy, o_bck, o_lr, o_sd, o_fs, lr_exp;
    int          m, b;
    logic [31:0] sample, pmask;
    logic [47:0] e;
    @(posedge clk);
    clr      = (sel ? rst1 : rst0) || !enable;
    load     = !clr && (run_cnt % frame_p == 2 * bd - 1);
    accepted = load && in_valid;
    uf_exp   = load && !in_valid;
    if (accepted) exp_q.push_back({in_left & smask, in_right & smask});
    if (uf_exp) exp_q.push_back(48'h0);
    if (clr) begin
      run_cnt = 0;
      exp_q.delete();
      rx_clear();
    end else begin
      run_cnt++;
    end
    @(negedge clk);
    o_rdy  = sel ? rdy1 : rdy0;
    o_bck  = sel ? bck1 : bck0;
    o_lr   = sel ? lrck1 : lrck0;
    o_sd   = sel ? sd1 : sd0;
    obs_uf = sel ? uf1 : uf0;
    o_fs   = sel ? fs1 : fs0;
    m = run_cnt / (2 * bd);
    b = (2 * SLOT - 2 + m) % (2 * SLOT);
    lr_exp = (m != 0) && (b >= SLOT - 1) && (b <= 2 * SLOT - 2);
    chk("in_ready", 64'(o_rdy), 64'(!clr && (run_cnt % frame_p == 2 * bd - 1)));
    chk("bck", 64'(o_bck), 64'((run_cnt / bd) % 2));
    chk("lrck", 64'(o_lr), 64'(lr_exp));
    chk("underflow", 64'(obs_uf), 64'(uf_exp));
    chk("frame_start", 64'(o_fs), 64'(run_cnt > 0 && run_cnt % frame_p == 4 * bd));
    if (run_cnt < 2 * bd) chk("sdata_idle", 64'(o_sd), 64'(0));
    // I2S receiver: sample on bck rise; the bit sampled when lrck changes is
    // the last bit of the word that just ended.
    if (o_bck === 1'b1 && rx_bck_prev === 1'b0) begin
      rx_word = {rx_word[30:0], o_sd};
      rx_cnt++;
      if (o_lr !== rx_lr_prev) begin
        if (rx_cnt >= SLOT) begin
          sample = rx_word >> (SLOT - sw);
          pmask  = 32'hFFFF_FFFF >> sw;
          chk("rx_pad_zero", 64'(rx_word & pmask), 64'(0));
          if (o_lr === 1'b1) begin
            rx_left      = 24'(sample);
            rx_have_left = 1'b1;
          end else if (rx_have_left) begin
            rx_pairs++;
            rx_have_left = 1'b0;
            chk("rx_pair_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("rx_left", 64'(rx_left), 64'(e[47:24]));
              chk("rx_right", 64'(sample), 64'(e[23:0]));
            end
          end
        end
        rx_cnt = 0;
      end
      rx_lr_prev = o_lr;
    end
    rx_bck_prev = o_bck;
  endtask

  task automatic send_pair(input logic [23:0] l, input logic [23:0] r, output int waited);
    logic got;
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    waited   = 0;
    got      = 1'b0;
    while (!got && waited < frame_p + 16) begin
      tick();
      waited++;
      got = accepted;
    end
    chk("pair_accepted", 64'(got), 64'(1));
  endtask

  task automatic wait_underflow();
    int   n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < frame_p + 16) begin
      tick();
      n++;
      seen = (obs_uf === 1'b1);
    end
    chk("gap_underflow_pulse", 64'(seen), 64'(1));
  endtask

  task automatic wait_rx(input int target);
    int n;
    n = 0;
    while (rx_pairs < target && n < 3 * frame_p) begin
      tick();
      n++;
    end
    chk("rx_pair_count", 64'(rx_pairs), 64'(target));
  endtask

  initial begin
    int w, n, rxb;
    // Instance 0: default geometry.
    sel = 1'b0; bd = 4; sw = 24; frame_p = 4 * SLOT * bd; smask = 24'hFF_FFFF;
    rst0 = 1'b1; rst1 = 1'b1; enable = 1'b1;
    in_valid = 1'b1; in_left = 24'hA5A5A5; in_right = 24'h5A5A5A;
    run_cnt = 0; rx_pairs = 0; rx_word = '0; rx_left = '0; rx_clear();
    accepted = 1'b0; uf_exp = 1'b0; obs_uf = 1'b0;
    repeat (3) tick();
    chk("reset_sdata", 64'(sd0), 64'(0));
    chk("reset_underflow", 64'(uf0), 64'(0));
    chk("reset_frame_start", 64'(fs0), 64'(0));
    rst0 = 1'b0;
    send_pair(24'hA5A5A5, 24'h5A5A5A, w);
    chk("first_ready_cycle", 64'(w), 64'(2 * bd));
    for (int i = 1; i <= 4; i++) begin
      send_pair(24'(i), 24'h800000 | 24'(i), w);
      chk("back_to_back_wait", 64'(w), 64'(frame_p));
    end
    for (int i = 5; i <= 7; i++) send_pair(24'($urandom), 24'($urandom), w);
    in_valid = 1'b0;
    wait_underflow();
    send_pair(24'($urandom), 24'($urandom), w);
    in_valid = 1'b0;
    wait_rx(10);

    // Enable drop at left-slot bit 10 while a pair is in flight.
    send_pair(24'h111111, 24'h222222, w);
    in_valid = 1'b0;
    n = 0;
    while (run_cnt % frame_p != 2 * bd * 12 && n < frame_p) begin
      tick();
      n++;
    end
    chk("drop_point_reached", 64'(run_cnt % frame_p), 64'(2 * bd * 12));
    rxb = rx_pairs;
    enable = 1'b0;
    tick();
    chk("drop_sdata", 64'(sd0), 64'(0));
    repeat (4) tick();
    chk("drop_no_rx", 64'(rx_pairs), 64'(rxb));
    enable = 1'b1;
    send_pair(24'h333333, 24'h444444, w);
    chk("reenable_ready_cycle", 64'(w), 64'(2 * bd));
    in_valid = 1'b0;
    wait_rx(rxb + 1);

    // Instance 1: 16-bit samples, bck toggling every clk.
    rst0 = 1'b1; rst1 = 1'b1;
    sel = 1'b1; bd = 1; sw = 16; frame_p = 4 * SLOT * bd; smask = 24'h00_FFFF;
    in_valid = 1'b1; in_left = 24'($urandom); in_right = 24'($urandom);
    repeat (3) tick();
    chk("b_reset_sdata", 64'(sd1), 64'(0));
    rx_pairs = 0;
    rst1 = 1'b0;
    send_pair(24'($urandom), 24'($urandom), w);
    chk("b_first_ready_cycle", 64'(w), 64'(2 * bd));
    for (int i = 0; i < 3; i++) begin
      send_pair(24'($urandom), 24'($urandom), w);
      chk("b_back_to_back_wait", 64'(w), 64'(frame_p));
    end
    in_valid = 1'b0;
    wait_underflow();
    send_pair(24'($urandom), 24'($urandom), w);
    in_valid = 1'b0;
    wait_rx(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
